// File: rtl/ic_cpu_bus_arbiter.sv
// ic_cpu_bus_arbiter
//   Shares one CPU memory bus between the instruction port (requester 0) and
//   the data port (requester 1). Every accepted request pushes its owner id
//   into an in-order FIFO so responses are steered back to the right port.
//   Both channels are purely combinational through the arbiter (zero added
//   latency); only selection/lock/FIFO bookkeeping is registered.
//
//   Optional feature macro: IC_CPU_BUS_ARB_RR_EN
//     defined   -> round-robin on contention (tracks last_grant)
//     undefined -> fixed priority, requester 1 (data) wins contention
//
// Parameters
//   OUTSTANDING  owner FIFO depth = max accepted transactions awaiting response (1..4)
// Ports
//   m0_aclk, m0_aresetn            clock, async active-low reset
//   rN_req/rN_gnt                  requester N request handshake
//   rN_wen/strb/wdata/addr         requester N request fields
//   rN_recv/rN_ack                 requester N response handshake
//   rN_error/rN_rdata              requester N response payload
//   m_req/m_gnt                    downstream request handshake
//   m_wen/strb/wdata/addr          downstream request fields
//   m_recv/m_ack                   downstream response handshake
//   m_error/m_rdata                downstream response payload
module ic_cpu_bus_arbiter #(
  parameter int OUTSTANDING = 2
) (
  input  logic        m0_aclk,
  input  logic        m0_aresetn,
  // requester 0 (instruction)
  input  logic        r0_req,
  output logic        r0_gnt,
  input  logic        r0_wen,
  input  logic [3:0]  r0_strb,
  input  logic [31:0] r0_wdata,
  input  logic [31:0] r0_addr,
  output logic        r0_recv,
  input  logic        r0_ack,
  output logic        r0_error,
  output logic [31:0] r0_rdata,
  // requester 1 (data)
  input  logic        r1_req,
  output logic        r1_gnt,
  input  logic        r1_wen,
  input  logic [3:0]  r1_strb,
  input  logic [31:0] r1_wdata,
  input  logic [31:0] r1_addr,
  output logic        r1_recv,
  input  logic        r1_ack,
  output logic        r1_error,
  output logic [31:0] r1_rdata,
  // downstream
  output logic        m_req,
  input  logic        m_gnt,
  output logic        m_wen,
  output logic [3:0]  m_strb,
  output logic [31:0] m_wdata,
  output logic [31:0] m_addr,
  input  logic        m_recv,
  output logic        m_ack,
  input  logic        m_error,
  input  logic [31:0] m_rdata
);

  localparam int CW = $clog2(OUTSTANDING + 1);
  localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;

  // owner FIFO
  logic [OUTSTANDING-1:0] own_q;
  logic [PW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   fifo_full, fifo_empty, head;

  // lock keeps an ungranted downstream request pinned to its requester
  logic lock_valid_q, lock_id_q;

  logic sel, sel_req, push, pop;

`ifdef IC_CPU_BUS_ARB_RR_EN
  logic last_grant_q;
`endif

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(OUTSTANDING - 1)) return '0;
    return p + PW'(1);
  endfunction

  assign fifo_full  = (cnt_q == CW'(OUTSTANDING));
  assign fifo_empty = (cnt_q == '0);
  assign head       = own_q[rd_ptr_q];

  // ---------------- selection ----------------
  always_comb begin
    sel = 1'b0;
    if (lock_valid_q)          sel = lock_id_q;
    else if (r0_req && r1_req) begin
`ifdef IC_CPU_BUS_ARB_RR_EN
      sel = ~last_grant_q;
`else
      sel = 1'b1;
`endif
    end
    else                       sel = r1_req;  // lone requester (or nobody)
  end

  assign sel_req = sel ? r1_req : r0_req;

  // ---------------- request path ----------------
  always_comb begin
    m_req   = sel_req && !fifo_full;
    m_wen   = 1'b0;
    m_strb  = '0;
    m_wdata = '0;
    m_addr  = '0;
    if (sel_req) begin
      m_wen   = sel ? r1_wen   : r0_wen;
      m_strb  = sel ? r1_strb  : r0_strb;
      m_wdata = sel ? r1_wdata : r0_wdata;
      m_addr  = sel ? r1_addr  : r0_addr;
    end
    r0_gnt = !sel && m_req && m_gnt;
    r1_gnt =  sel && m_req && m_gnt;
  end

  // ---------------- response path ----------------
  always_comb begin
    r0_recv  = m_recv && !fifo_empty && !head;
    r1_recv  = m_recv && !fifo_empty &&  head;
    // responses with no tracked owner are neither forwarded nor accepted
    m_ack    = !fifo_empty && (head ? r1_ack : r0_ack);
    r0_rdata = r0_recv ? m_rdata : '0;
    r1_rdata = r1_recv ? m_rdata : '0;
    r0_error = r0_recv && m_error;
    r1_error = r1_recv && m_error;
  end

  assign push = m_req && m_gnt;
  assign pop  = m_recv && m_ack;

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;  // idle, or push+pop keeps occupancy
    endcase
  end

  // ---------------- state ----------------
  always_ff @(posedge m0_aclk or negedge m0_aresetn) begin
    if (!m0_aresetn) begin
      own_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (push) begin
        own_q[wr_ptr_q] <= sel;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
    end
  end

  always_ff @(posedge m0_aclk or negedge m0_aresetn) begin
    if (!m0_aresetn) begin
      lock_valid_q <= 1'b0;
      lock_id_q    <= 1'b0;
    end else if (m_req && !m_gnt) begin
      lock_valid_q <= 1'b1;
      lock_id_q    <= sel;
    end else if (push) begin
      lock_valid_q <= 1'b0;
    end
  end

`ifdef IC_CPU_BUS_ARB_RR_EN
  always_ff @(posedge m0_aclk or negedge m0_aresetn) begin
    if (!m0_aresetn)  last_grant_q <= 1'b0;
    else if (push)    last_grant_q <= sel;
  end
`endif

endmodule
